// File: rtl/serial_adder_seq_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_seq_fa_cell.sv
// Combinational 1-bit full adder stepped by serial_adder_seq.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ ci;
  assign cout = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder step per clock, LSB first, carry held in a flop.
// Optional subtract mode and signed-overflow flag when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_seq
  import serial_adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
  output logic             out_ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .ci   (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b computed as a + ~b + 1
          if (in_sub) begin
            b_d     = ~in_b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_SUB_EN
          // carry_q is the carry into the MSB on the final step
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
